// File: rtl/d32x5_pkg.sv
// Shared types and constants for the d32x5 registered 1-to-5 word demultiplexer.
package d32x5_pkg;

   localparam int NPORT = 5;
   localparam int SEL_W = 3;
   localparam int DW    = 32;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [DW-1:0]    data;
   } entry_t;

   function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
      return sel < SEL_W'(NPORT);
   endfunction

endpackage

// File: rtl/d32x5_fifo2.sv
// Two-entry synchronous FIFO of {sel,data} entries; head visible the cycle after push.
// Backpressure via o_full; once empty, o_head keeps showing the last popped entry.
module d32x5_fifo2
   import d32x5_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   i_push,
   input  entry_t i_push_dat,
   input  logic   i_pop,
   output logic   o_full,
   output logic   o_empty,
   output entry_t o_head
);

   entry_t     r_mem [2];
   logic [1:0] r_count;
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic       w_rd_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
         r_count  <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full  = (r_count == 2'(DEPTH));
   assign o_empty = (r_count == 2'd0);

   // When empty, the slot behind rd_ptr still holds the last popped word and
   // cannot be overwritten before the FIFO becomes non-empty again.
   assign w_rd_idx = o_empty ? ~r_rd_ptr : r_rd_ptr;
   assign o_head   = r_mem[w_rd_idx];

endmodule

// File: rtl/d32x5.sv
// Registered 1-to-5 demux: 1-cycle latency, 1 word/cycle, illegal codes dropped and counted.
// Backpressure: in_ready low while the 2-entry FIFO is full; head-of-line blocking across ports.
module d32x5
   import d32x5_pkg::*;
#(
   parameter int DW    = 32,
   parameter int NPORT = 5,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic [2:0]       in_sel,
   output logic [NPORT-1:0] out_valid,
   input  logic [NPORT-1:0] out_ready,
   output logic [DW-1:0]    out_data,
   output logic             err,
   input  logic             err_clr,
   output logic [7:0]       drop_cnt
);

   logic       w_full;
   logic       w_empty;
   logic       w_accept;
   logic       w_legal;
   logic       w_push;
   logic       w_pop;
   entry_t     w_push_dat;
   entry_t     w_head;
   logic       r_err;
   logic [7:0] r_drop_cnt;

   assign w_accept   = in_valid & ~w_full;
   assign w_legal    = sel_legal(in_sel);
   assign w_push     = w_accept & w_legal;
   assign w_push_dat = '{sel: in_sel, data: in_data};
   assign w_pop      = |(out_valid & out_ready);

   d32x5_fifo2 #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_head     (w_head)
   );

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < NPORT; i++)
         out_valid[i] = ~w_empty & (w_head.sel == 3'(i));
   end

   assign out_data = w_head.data;
   assign in_ready = ~w_full;

   // A clear in the same cycle as an illegal word suppresses counting it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (err_clr) begin
         r_err      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_accept && !w_legal) begin
         r_err <= 1'b1;
         if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign err      = r_err;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_d32x5.sv
// Directed bench for d32x5: inputs change and outputs are sampled on the falling edge.
module tb_d32x5;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  in_sel;
   logic [4:0]  out_valid;
   logic [4:0]  out_ready;
   logic [31:0] out_data;
   logic        err;
   logic        err_clr;
   logic [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   d32x5 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .err_clr   (err_clr),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [2:0] sel, input logic [31:0] dat);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = dat;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [4:0] exp_v;
      reset_n   = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      out_ready = '0;
      err_clr   = 1'b0;
      #3 reset_n = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single word to port 3
      out_ready = 5'b01000;
      push(3'd3, 32'hDEADBEEF);
      chk("single_valid", 32'(out_valid), 32'h08);
      chk("single_data", out_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("single_done_valid", 32'(out_valid), 32'd0);
      chk("single_hold_data", out_data, 32'hDEADBEEF);

      // Backpressure and full
      out_ready = 5'b00000;
      push(3'd0, 32'h000000A0);
      chk("bp_ready_one", 32'(in_ready), 32'd1);
      chk("bp_head0_valid", 32'(out_valid), 32'h01);
      push(3'd4, 32'h000000A4);
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      chk("bp_full_valid", 32'(out_valid), 32'h01);
      chk("bp_full_data", out_data, 32'h000000A0);
      out_ready = 5'b00001;
      @(negedge clk);
      chk("bp_pop_valid", 32'(out_valid), 32'h10);
      chk("bp_pop_data", out_data, 32'h000000A4);
      chk("bp_pop_ready", 32'(in_ready), 32'd1);
      out_ready = 5'b10000;
      @(negedge clk);
      chk("bp_empty_valid", 32'(out_valid), 32'd0);

      // Head-of-line blocking
      out_ready = 5'b00100;
      push(3'd1, 32'h00000011);
      push(3'd2, 32'h00000022);
      chk("hol_block_valid", 32'(out_valid), 32'h02);
      chk("hol_block_data", out_data, 32'h00000011);
      @(negedge clk);
      chk("hol_still_valid", 32'(out_valid), 32'h02);
      chk("hol_still_ready", 32'(in_ready), 32'd0);
      out_ready = 5'b00110;
      @(negedge clk);
      chk("hol_second_valid", 32'(out_valid), 32'h04);
      chk("hol_second_data", out_data, 32'h00000022);
      @(negedge clk);
      chk("hol_empty_valid", 32'(out_valid), 32'd0);

      // Streaming: one delivery per cycle, in order, no gaps
      out_ready = 5'b11111;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_sel   = 3'(i % 5);
         in_data  = 32'h100 + 32'(i);
         @(negedge clk);
         exp_v = 5'b00001 << (i % 5);
         chk("stream_valid", 32'(exp_v), 32'(out_valid));
         chk("stream_data", out_data, 32'h100 + 32'(i));
         chk("stream_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_drain", 32'(out_valid), 32'd0);

      // Illegal codes
      out_ready = 5'b00000;
      push(3'd5, 32'h55555555);
      chk("ill5_valid", 32'(out_valid), 32'd0);
      push(3'd6, 32'h66666666);
      push(3'd7, 32'h77777777);
      chk("ill_valid", 32'(out_valid), 32'd0);
      chk("ill_ready", 32'(in_ready), 32'd1);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_cnt", 32'(drop_cnt), 32'd3);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_cnt", 32'(drop_cnt), 32'd0);
      err_clr = 1'b1;
      push(3'd5, 32'h0);
      err_clr = 1'b0;
      chk("clr_wins_err", 32'(err), 32'd0);
      chk("clr_wins_cnt", 32'(drop_cnt), 32'd0);
      in_valid = 1'b1;
      in_sel   = 3'd6;
      repeat (254) @(negedge clk);
      chk("sat_254", 32'(drop_cnt), 32'd254);
      repeat (46) @(negedge clk);
      in_valid = 1'b0;
      chk("sat_cnt", 32'(drop_cnt), 32'd255);
      chk("sat_err", 32'(err), 32'd1);
      chk("sat_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset while full
      push(3'd2, 32'h00000B02);
      push(3'd3, 32'h00000B03);
      chk("prerst_ready", 32'(in_ready), 32'd0);
      chk("prerst_valid", 32'(out_valid), 32'h04);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data", out_data, 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_cnt", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("postrst_valid", 32'(out_valid), 32'd0);
      chk("postrst_ready", 32'(in_ready), 32'd1);
      out_ready = 5'b00100;
      push(3'd2, 32'h00000055);
      chk("postrst_push_valid", 32'(out_valid), 32'h04);
      chk("postrst_push_data", out_data, 32'h00000055);
      @(negedge clk);
      chk("postrst_pop_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
